// File: rtl/ram_addr_reverse_if.sv
// Request/response bundle between the RAM bus monitor, the address reverse
// mapper and the trap/debug unit.
interface ram_addr_reverse_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_phys_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [3:0]        rsp_prog;
  logic [ADDR_W-1:0] rsp_local_addr;
  logic              rsp_os;
  logic              rsp_fault;

  modport master (
    output req_valid, req_phys_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_prog, rsp_local_addr, rsp_os, rsp_fault
  );

  modport slave (
    input  req_valid, req_phys_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_prog, rsp_local_addr, rsp_os, rsp_fault
  );
endinterface

// File: rtl/ram_addr_reverse.sv
// Reverse RAM offset map: physical address -> (owner program, local address),
// or OS / unmapped fault, with a single-entry response register and fault tally.
module ram_addr_reverse #(
  parameter int ADDR_W    = 12,
  parameter int PAGE_BITS = 8,
  parameter int NUM_PROGS = 10,
  parameter int FCNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  ram_addr_reverse_if.slave   bus,
  input  logic                fault_clr,
  output logic [FCNT_W-1:0]   fault_count,
  output logic [ADDR_W-1:0]   last_fault_addr
);

  localparam int PAGE_W = ADDR_W - PAGE_BITS;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              accept_s;
  logic              req_ready_s;

  logic [PAGE_W-1:0] page_s;
  logic [3:0]        dec_prog_s;
  logic [ADDR_W-1:0] dec_local_s;
  logic              dec_os_s;
  logic              dec_fault_s;

  logic [3:0]        rsp_prog_q, rsp_prog_d;
  logic [ADDR_W-1:0] rsp_local_q, rsp_local_d;
  logic              rsp_os_q, rsp_os_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [FCNT_W-1:0] fault_count_q, fault_count_d;
  logic [ADDR_W-1:0] last_fault_q, last_fault_d;

  // Handshake outputs: the response register can take a new result when empty
  // or when it is being drained this same cycle.
  always_comb begin
    req_ready_s = (state_q == EMPTY) || bus.rsp_ready;
    accept_s    = bus.req_valid && req_ready_s;
  end

  // Next-state logic for the one-entry response register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) state_d = FULL;
        else          state_d = EMPTY;
      end
      FULL: begin
        if (bus.rsp_ready && !accept_s) state_d = EMPTY;
        else                            state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Page decode: page 0 is the OS, pages 1..NUM_PROGS map to programs 0..N-1.
  always_comb begin
    page_s      = bus.req_phys_addr[ADDR_W-1:PAGE_BITS];
    dec_os_s    = 1'b0;
    dec_fault_s = 1'b0;
    dec_prog_s  = 4'hF;
    dec_local_s = {ADDR_W{1'b0}};
    if (page_s == {PAGE_W{1'b0}}) begin
      dec_os_s    = 1'b1;
      dec_local_s = bus.req_phys_addr;
    end else if (page_s <= PAGE_W'(NUM_PROGS)) begin
      dec_prog_s  = 4'(page_s - PAGE_W'(1));
      dec_local_s = {{PAGE_W{1'b0}}, bus.req_phys_addr[PAGE_BITS-1:0]};
    end else begin
      dec_fault_s = 1'b1;
    end
  end

  // Response fields load only on accept, so they hold while stalled.
  always_comb begin
    rsp_prog_d  = rsp_prog_q;
    rsp_local_d = rsp_local_q;
    rsp_os_d    = rsp_os_q;
    rsp_fault_d = rsp_fault_q;
    if (accept_s) begin
      rsp_prog_d  = dec_prog_s;
      rsp_local_d = dec_local_s;
      rsp_os_d    = dec_os_s;
      rsp_fault_d = dec_fault_s;
    end else begin
      rsp_prog_d  = rsp_prog_q;
    end
  end

  // Fault tally: a clear coinciding with an accepted fault counts that fault.
  always_comb begin
    fault_count_d = fault_count_q;
    last_fault_d  = last_fault_q;
    if (fault_clr) begin
      if (accept_s && dec_fault_s) begin
        fault_count_d = {{(FCNT_W-1){1'b0}}, 1'b1};
        last_fault_d  = bus.req_phys_addr;
      end else begin
        fault_count_d = {FCNT_W{1'b0}};
        last_fault_d  = {ADDR_W{1'b0}};
      end
    end else if (accept_s && dec_fault_s) begin
      last_fault_d = bus.req_phys_addr;
      if (fault_count_q != {FCNT_W{1'b1}}) begin
        fault_count_d = fault_count_q + {{(FCNT_W-1){1'b0}}, 1'b1};
      end else begin
        fault_count_d = fault_count_q;
      end
    end else begin
      fault_count_d = fault_count_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= EMPTY;
      rsp_prog_q    <= 4'hF;
      rsp_local_q   <= {ADDR_W{1'b0}};
      rsp_os_q      <= 1'b0;
      rsp_fault_q   <= 1'b0;
      fault_count_q <= {FCNT_W{1'b0}};
      last_fault_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q       <= state_d;
      rsp_prog_q    <= rsp_prog_d;
      rsp_local_q   <= rsp_local_d;
      rsp_os_q      <= rsp_os_d;
      rsp_fault_q   <= rsp_fault_d;
      fault_count_q <= fault_count_d;
      last_fault_q  <= last_fault_d;
    end
  end

  assign bus.req_ready      = req_ready_s;
  assign bus.rsp_valid      = (state_q == FULL);
  assign bus.rsp_prog       = rsp_prog_q;
  assign bus.rsp_local_addr = rsp_local_q;
  assign bus.rsp_os         = rsp_os_q;
  assign bus.rsp_fault      = rsp_fault_q;
  assign fault_count        = fault_count_q;
  assign last_fault_addr    = last_fault_q;

endmodule

// File: tb/tb_ram_addr_reverse.sv
// Directed bench for ram_addr_reverse: expected responses are queued on
// accept and compared when the response handshake completes.
module tb_ram_addr_reverse;

  localparam int ADDR_W = 12;
  localparam int FCNT_W = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              fault_clr = 1'b0;
  logic [FCNT_W-1:0] fault_count;
  logic [ADDR_W-1:0] last_fault_addr;

  ram_addr_reverse_if #(.ADDR_W(ADDR_W)) bus ();

  ram_addr_reverse #(
    .ADDR_W(ADDR_W), .PAGE_BITS(8), .NUM_PROGS(10), .FCNT_W(FCNT_W)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .bus             (bus),
    .fault_clr       (fault_clr),
    .fault_count     (fault_count),
    .last_fault_addr (last_fault_addr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] phys;
    logic [3:0]  prog;
    logic [11:0] loc;
    logic        os;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [11:0] a);
    exp_t e;
    e.phys  = a;
    e.os    = 1'b0;
    e.fault = 1'b0;
    e.prog  = 4'hF;
    e.loc   = 12'h000;
    if (a < 12'h100) begin
      e.os  = 1'b1;
      e.loc = a;
    end else if (a < 12'hB00) begin
      e.prog = 4'(a[11:8] - 4'd1);
      e.loc  = {4'h0, a[7:0]};
    end else begin
      e.fault = 1'b1;
    end
    return e;
  endfunction

  // One cycle: inputs were driven after the falling edge; observe, then advance.
  task automatic tick();
    exp_t e;
    #1;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_prog",  32'(bus.rsp_prog),       32'(e.prog));
        check("rsp_local", 32'(bus.rsp_local_addr), 32'(e.loc));
        check("rsp_os",    32'(bus.rsp_os),         32'(e.os));
        check("rsp_fault", 32'(bus.rsp_fault),      32'(e.fault));
        if (!e.os && !e.fault)
          check("round_trip",
                (32'(bus.rsp_prog) + 32'd1) * 32'd256 + 32'(bus.rsp_local_addr),
                32'(e.phys));
      end
    end
    if (bus.req_valid && bus.req_ready) sb.push_back(model(bus.req_phys_addr));
    @(negedge clock);
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
    #1 check("idle_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(bus.rsp_valid),      32'd0);
    check({tag, "_prog"},  32'(bus.rsp_prog),       32'hF);
    check({tag, "_local"}, 32'(bus.rsp_local_addr), 32'd0);
    check({tag, "_os"},    32'(bus.rsp_os),         32'd0);
    check({tag, "_fault"}, 32'(bus.rsp_fault),      32'd0);
    check({tag, "_fcnt"},  32'(fault_count),        32'd0);
    check({tag, "_last"},  32'(last_fault_addr),    32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready),      32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    logic [11:0] last_a;
    bus.req_valid     = 1'b0;
    bus.req_phys_addr = 12'h000;
    bus.rsp_ready     = 1'b0;
    last_a            = 12'h000;

    repeat (2) @(negedge clock);
    #1 check_reset("por");
    reset_n = 1'b1;
    @(negedge clock);

    // Reset pulse mid-cycle with a response pending
    bus.req_valid = 1'b1; bus.req_phys_addr = 12'hB50;
    tick();
    bus.req_valid = 1'b0;
    #1 check("pend_valid", 32'(bus.rsp_valid), 32'd1);
    check("pend_fcnt", 32'(fault_count), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset("midrst");
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed decode
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_phys_addr = 12'h042; tick();
    bus.req_phys_addr = 12'h1A7; tick();
    bus.req_phys_addr = 12'hAFF; tick();
    bus.req_phys_addr = 12'hB00; tick();
    drain();

    // Backpressure then back-to-back stream
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_phys_addr = 12'h2A5;
    tick();
    bus.req_phys_addr = 12'h300;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 32'(bus.req_ready),      32'd0);
      check("bp_valid", 32'(bus.rsp_valid),      32'd1);
      check("bp_prog",  32'(bus.rsp_prog),       32'd1);
      check("bp_local", 32'(bus.rsp_local_addr), 32'h0A5);
      @(negedge clock);
    end
    bus.rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.req_phys_addr = 12'(12'h100 + i);
      check("stream_ready", 32'(bus.req_ready), 32'd1);
      tick();
    end
    drain();

    // Fault tally
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    #1 check("clr_fcnt", 32'(fault_count), 32'd0);
    check("clr_last", 32'(last_fault_addr), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_phys_addr = 12'hC00; tick();
    bus.req_phys_addr = 12'hD10; tick();
    bus.req_phys_addr = 12'hFFF; tick();
    drain();
    check("f3_fcnt", 32'(fault_count),     32'd3);
    check("f3_last", 32'(last_fault_addr), 32'hFFF);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = 12'($urandom_range(32'hB00, 32'hFFF));
      bus.req_phys_addr = a;
      last_a = a;
      tick();
    end
    drain();
    check("sat_fcnt", 32'(fault_count),     32'd255);
    check("sat_last", 32'(last_fault_addr), 32'(last_a));

    // Clear racing an accepted fault, then clear alone
    bus.req_valid = 1'b1; bus.req_phys_addr = 12'hE00; fault_clr = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    #1 check("race_fcnt", 32'(fault_count),     32'd1);
    check("race_last", 32'(last_fault_addr), 32'hE00);
    tick();
    fault_clr = 1'b0;
    #1 check("alone_fcnt", 32'(fault_count),     32'd0);
    check("alone_last", 32'(last_fault_addr), 32'd0);
    drain();

    // Random round-trip over program windows
    bus.req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.req_phys_addr = 12'($urandom_range(32'h100, 32'hAFF));
      tick();
    end
    drain();
    check("rt_fcnt", 32'(fault_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
